// File: rtl/pokey_pkg.sv
// Shared constants for the POKEY scan-side keyboard models.
package pokey_pkg;

  localparam int SCAN_W             = 6;
  localparam int KEY_COUNT          = 64;
  localparam int DEFAULT_MIN_PASSES = 2;

  typedef logic [SCAN_W-1:0] scan_idx_t;

  localparam scan_idx_t SCAN_LAST      = 6'h3F;
  localparam scan_idx_t KEY_SHIFT_SLOT = 6'h10;
  localparam scan_idx_t KEY_CTRL_SLOT  = 6'h00;
  localparam scan_idx_t KEY_BREAK_SLOT = 6'h30;

endpackage

// File: rtl/pokey_scan_pass_detect.sv
// Detects a completed scan pass: the index wrapping from the last slot back to slot 0.
module pokey_scan_pass_detect
  import pokey_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [SCAN_W-1:0] idx,
  output logic            pass_tick
);

  scan_idx_t prev_idx;

  // Scan may stall on a slot; only a genuine 63 -> 0 step is a pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_idx <= '0;
    else          prev_idx <= idx;
  end

  assign pass_tick = (prev_idx == SCAN_LAST) && (idx == '0);

endmodule

// File: rtl/pokey_keyboard_matrix.sv
// Atari keyboard matrix seen from the POKEY scan lines, with tap stretching
// so short host key taps and break pulses survive POKEY's debounce.
module pokey_keyboard_matrix
  import pokey_pkg::*;
#(
  parameter int MIN_PASSES = DEFAULT_MIN_PASSES,
  parameter int PASS_W     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] keyboard_scan,
  output logic [1:0] keyboard_response,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [5:0] key_code,
  input  logic       key_make,
  input  logic       shift_in,
  input  logic       ctrl_in,
  input  logic       break_in,
  input  logic       flush,
  output logic       keys_down
);

  localparam logic [PASS_W-1:0] PASS_SAT = PASS_W'(MIN_PASSES);

  scan_idx_t              idx;
  logic                   pass_tick;
  logic [KEY_COUNT-1:0]   bitmap;
  scan_idx_t              last_code;
  logic                   last_valid;
  logic [PASS_W-1:0]      pass_cnt;
  logic                   break_hold;
  logic                   break_prev;
  logic [1:0]             brk_cnt;
  logic                   stall;
  logic                   accept;
  logic                   break_rise;

  assign idx = ~keyboard_scan;

  pokey_scan_pass_detect u_pass_detect (
    .clk       (clk),
    .reset_n   (reset_n),
    .idx       (idx),
    .pass_tick (pass_tick)
  );

  // A release of the most recent press waits until POKEY has seen it for enough passes.
  assign stall      = key_valid && !key_make && last_valid &&
                      (key_code == last_code) && (pass_cnt < PASS_SAT);
  assign key_ready  = !flush && !stall;
  assign accept     = key_valid && key_ready;
  assign break_rise = break_in && !break_prev;

  always_comb begin
    keyboard_response[0] = ~bitmap[idx];
    keyboard_response[1] = 1'b1;
    case (idx)
      KEY_CTRL_SLOT:  keyboard_response[1] = ~ctrl_in;
      KEY_SHIFT_SLOT: keyboard_response[1] = ~shift_in;
      KEY_BREAK_SLOT: keyboard_response[1] = ~(break_in | break_hold);
      default:        keyboard_response[1] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitmap     <= '0;
      last_code  <= '0;
      last_valid <= 1'b0;
      pass_cnt   <= PASS_SAT;
      break_hold <= 1'b0;
      break_prev <= 1'b0;
      brk_cnt    <= '0;
      keys_down  <= 1'b0;
    end else begin
      break_prev <= break_in;
      keys_down  <= |bitmap;
      if (flush) begin
        bitmap     <= '0;
        last_valid <= 1'b0;
        pass_cnt   <= PASS_SAT;
        break_hold <= 1'b0;
        brk_cnt    <= '0;
      end else begin
        if (accept && key_make) begin
          bitmap[key_code] <= 1'b1;
          last_code        <= key_code;
          last_valid       <= 1'b1;
          pass_cnt         <= '0;
        end else begin
          if (pass_tick && (pass_cnt < PASS_SAT)) pass_cnt <= pass_cnt + 1'b1;
          if (accept) begin
            bitmap[key_code] <= 1'b0;
            if (key_code == last_code) last_valid <= 1'b0;
          end
        end
        // Break is held for two full passes after its rising edge.
        if (break_rise) begin
          break_hold <= 1'b1;
          brk_cnt    <= '0;
        end else if (break_hold && pass_tick) begin
          if (brk_cnt == 2'd1) begin
            break_hold <= 1'b0;
            brk_cnt    <= '0;
          end else begin
            brk_cnt <= brk_cnt + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pokey_keyboard_matrix.sv
// Randomized self-checking bench for pokey_keyboard_matrix against a key-list reference model.
module tb_pokey_keyboard_matrix;

  localparam int MIN_P = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] keyboard_scan;
  logic [1:0] keyboard_response;
  logic       key_valid;
  logic       key_ready;
  logic [5:0] key_code;
  logic       key_make;
  logic       shift_in;
  logic       ctrl_in;
  logic       break_in;
  logic       flush;
  logic       keys_down;

  int checks = 0;
  int failures = 0;

  int pos = 0;
  bit g_shift = 0, g_ctrl = 0, g_brk = 0;

  bit m_down[64];
  int m_last = 0;
  bit m_last_on = 0;
  int m_passes = MIN_P;
  int m_brk_left = 0;
  bit m_brk_prev = 0;
  int m_prev = 0;
  bit m_kd = 0;

  pokey_keyboard_matrix #(.MIN_PASSES(MIN_P), .PASS_W(3)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .keyboard_scan     (keyboard_scan),
    .keyboard_response (keyboard_response),
    .key_valid         (key_valid),
    .key_ready         (key_ready),
    .key_code          (key_code),
    .key_make          (key_make),
    .shift_in          (shift_in),
    .ctrl_in           (ctrl_in),
    .break_in          (break_in),
    .flush             (flush),
    .keys_down         (keys_down)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t idx=%0d: got %0h, want %0h", tag, $time, pos, actual, expected);
    end
  endtask

  function automatic bit modelStalls(input bit valid, input int code, input bit make);
    return valid && !make && m_last_on && (code == m_last) && (m_passes < MIN_P);
  endfunction

  // One clock: drive after negedge, check combinational/registered outputs, then advance the model.
  task automatic applyStimulus(input bit valid, input int code, input bit make, input bit fl, input bit advance);
    bit exp_r0, exp_r1, exp_ready, tick, accept, any;
    @(negedge clk);
    if (advance) pos = (pos + 1) % 64;
    keyboard_scan = ~6'(pos);
    key_valid = valid;
    key_code  = 6'(code);
    key_make  = make;
    flush     = fl;
    shift_in  = g_shift;
    ctrl_in   = g_ctrl;
    break_in  = g_brk;
    #1;
    exp_r0 = !m_down[pos];
    if (pos == 'h00)      exp_r1 = !g_ctrl;
    else if (pos == 'h10) exp_r1 = !g_shift;
    else if (pos == 'h30) exp_r1 = !(g_brk || (m_brk_left > 0));
    else                  exp_r1 = 1'b1;
    exp_ready = !fl && !modelStalls(valid, code, make);
    checkOutput("response", {6'b0, keyboard_response}, {6'b0, exp_r1, exp_r0});
    checkOutput("key_ready", {7'b0, key_ready}, {7'b0, exp_ready});
    checkOutput("keys_down", {7'b0, keys_down}, {7'b0, m_kd});

    tick = (m_prev == 63) && (pos == 0);
    m_prev = pos;
    accept = valid && exp_ready;
    any = 0;
    foreach (m_down[i]) any |= m_down[i];
    m_kd = any;
    if (fl) begin
      foreach (m_down[i]) m_down[i] = 0;
      m_last_on = 0;
      m_passes = MIN_P;
      m_brk_left = 0;
    end else begin
      if (accept && make) begin
        m_down[code] = 1;
        m_last = code;
        m_last_on = 1;
        m_passes = 0;
      end else begin
        if (tick && m_passes < MIN_P) m_passes++;
        if (accept) begin
          m_down[code] = 0;
          if (code == m_last) m_last_on = 0;
        end
      end
      if (g_brk && !m_brk_prev) m_brk_left = 2;
      else if (tick && m_brk_left > 0) m_brk_left--;
    end
    m_brk_prev = g_brk;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    keyboard_scan = 6'h3F;
    key_valid = 0; key_code = 0; key_make = 0;
    shift_in = 0; ctrl_in = 0; break_in = 0; flush = 0;
    #2;
    checkOutput("reset_response", {6'b0, keyboard_response}, 8'h03);
    checkOutput("reset_key_ready", {7'b0, key_ready}, 8'h01);
    checkOutput("reset_keys_down", {7'b0, keys_down}, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] empty sweep");
    idle(70);

    $display("[TB] make 0x3F and sweep");
    applyStimulus(1, 'h3F, 1, 0, 1);
    idle(130);

    $display("[TB] tap 0x12 with early release");
    applyStimulus(1, 'h12, 1, 0, 1);
    n = 0;
    while (modelStalls(1, 'h12, 0) && n < 300) begin
      applyStimulus(1, 'h12, 0, 0, 1);
      n++;
    end
    checkOutput("release_bound", {7'b0, modelStalls(1, 'h12, 0)}, 8'h00);
    applyStimulus(1, 'h12, 0, 0, 1);
    idle(70);

    $display("[TB] modifiers");
    g_shift = 1; g_ctrl = 1;
    idle(70);
    g_shift = 0; g_ctrl = 0;

    $display("[TB] break pulse mid-pass");
    while (pos != 20) applyStimulus(0, 0, 0, 0, 1);
    g_brk = 1;
    applyStimulus(0, 0, 0, 0, 1);
    g_brk = 0;
    idle(200);

    $display("[TB] flush with concurrent make");
    applyStimulus(1, 'h05, 1, 0, 1);
    applyStimulus(1, 'h21, 1, 0, 1);
    idle(3);
    applyStimulus(1, 'h07, 1, 1, 1);
    idle(70);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      bit v, mk, fl, adv;
      int code;
      v   = ($urandom_range(0, 2) == 0);
      mk  = $urandom_range(0, 1);
      fl  = ($urandom_range(0, 63) == 0);
      adv = ($urandom_range(0, 7) != 0);
      code = ($urandom_range(0, 2) == 0) ? m_last : int'($urandom_range(0, 63));
      if ($urandom_range(0, 31) == 0) g_shift = !g_shift;
      if ($urandom_range(0, 31) == 0) g_ctrl = !g_ctrl;
      g_brk = ($urandom_range(0, 99) == 0);
      applyStimulus(v, code, mk, fl, adv);
    end
    g_brk = 0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
